// File: rtl/bcd_gray_conv.sv
// Packed BCD to binary or Gray converter.
// Reverse double-dabble, one shift per clock, valid/ready on both sides.
module bcd_gray_conv #(
    parameter int  DIGITS = 2,
    localparam int BW     = $clog2(10 ** DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BW-1:0]         code_out,
    output logic                  error,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BCDW = 4 * DIGITS;
    localparam int CW   = $clog2(BW + 1);
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [BCDW-1:0]   bcd_q;
    logic [BW-1:0]     bin_q;
    logic              mode_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     code_q;
    logic              err_q;

    logic [BCDW+BW-1:0] shift_d;
    logic [BCDW-1:0]    bcd_d;
    logic [BW-1:0]      bin_d;
    logic               bad_d;

    function automatic logic [BW-1:0] to_gray(input logic [BW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One reverse double-dabble step: shift right, then fix digits >= 8.
    always_comb begin
        shift_d = {bcd_q, bin_q} >> 1;
        bin_d   = shift_d[BW-1:0];
        bcd_d   = shift_d[BCDW+BW-1:BW];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i+3]) begin
                bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
            end
        end
    end

    // Flag any input nibble outside 0..9.
    always_comb begin
        bad_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad_d = 1'b1;
            end
        end
    end

    // Control FSM with registered result and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q  <= bcd;
                        mode_q <= mode;
                        bin_q  <= '0;
                        cnt_q  <= '0;
                        code_q <= '0;
                        if (bad_d) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        code_q  <= mode_q ? bin_d : to_gray(bin_d);
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        code_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign code_out  = code_q;
    assign error     = err_q;

endmodule

// File: doc/bcd_gray_conv.md
BCD_GRAY_CONV -- requirements
Module: bcd_gray_conv

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of packed BCD input digits (legal range 1..8).
REQ-002 The block SHALL have localparam BW = clog2(10**DIGITS), the binary/Gray output width (7 for DIGITS=2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port bcd, input, 4*DIGITS bits: packed BCD, most significant digit in the top nibble.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 selects Gray output, 1 selects plain binary output.
REQ-007 The block SHALL have port in_valid, input, 1 bit: bcd/mode are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-009 The block SHALL have port code_out, output, BW bits: the converted result.
REQ-010 The block SHALL have port error, output, 1 bit: the accepted input held a digit greater than 9; qualified by out_valid.
REQ-011 The block SHALL have port out_valid, output, 1 bit: code_out/error are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CONV and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Accept SHALL occur on a rising edge with state=IDLE and in_valid=1; the block SHALL register bcd and mode at accept, and later input changes SHALL have no effect on the result.
REQ-016 At accept, if any nibble is greater than 9, the block SHALL enter DONE on the same edge with error=1 and code_out=0, with no conversion performed.
REQ-017 At accept with all digits valid, the block SHALL clear the binary shift register and the cycle counter, and enter CONV.
REQ-018 Each CONV cycle SHALL perform one reverse double-dabble step.
- Shift the {BCD register, binary register} concatenation right by one.
- Then subtract 3 from every BCD digit that is 8 or more.
REQ-019 The counter SHALL count the CONV steps; after exactly BW steps the block SHALL enter DONE with error=0.
REQ-020 In DONE, code_out SHALL be bin ^ (bin >> 1) when the latched mode=0, and bin when the latched mode=1.
REQ-021 Latency for a valid input SHALL be: out_valid first high BW rising edges after the accept edge (7 edges for DIGITS=2).
REQ-022 Latency for an invalid input SHALL be: out_valid high on the edge following the accept edge.
REQ-023 In DONE, code_out, error and out_valid SHALL hold stable until out_ready=1 is sampled; the block SHALL then return to IDLE on that edge.
REQ-024 After DONE, in_ready SHALL rise one cycle after the output handshake; there SHALL be no same-cycle output/input overlap, giving a throughput of one result per BW+2 cycles.
REQ-025 in_valid asserted while the block is not in IDLE SHALL be ignored and SHALL NOT be accepted.
REQ-026 out_ready asserted outside DONE SHALL have no effect.
REQ-027 An all-zero input SHALL convert normally, giving code_out=0 and error=0 after BW cycles.
REQ-028 The maximum input (all digits 9) SHALL produce a result that fits in BW bits with no overflow.

Reset
REQ-029 While rst=1, regardless of clk, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, error=0, code_out=0, and all internal registers zeroed.
REQ-030 Reset asserted mid-CONV or in DONE SHALL abort the conversion immediately; the pending result SHALL be discarded and never presented.
REQ-031 After rst deasserts, the first accept SHALL be possible on the next rising edge.

Verification (DIGITS=2, BW=7)
REQ-032 The bench SHALL cover: bcd=0x45, mode=0, out_ready=1 -> out_valid 7 edges after accept, code_out=0x3B, error=0.
REQ-033 The bench SHALL cover: bcd=0x99, mode=0 -> code_out=0x52; and bcd=0x99, mode=1 -> code_out=0x63.
REQ-034 The bench SHALL cover: bcd=0x3A -> out_valid one edge after accept, error=1, code_out=0x00.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE while bcd/in_valid toggle -> outputs stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge.
REQ-036 The bench SHALL cover: rst pulsed at the 3rd CONV cycle of bcd=0x45 -> immediate IDLE, out_valid never asserted; then bcd=0x00 -> code_out=0x00 after 7 edges.
REQ-037 The bench SHALL cover: an exhaustive sweep of 00..99 in both modes against a reference model, plus a DIGITS=3 build with bcd=0x999 -> BW=10, mode=1 code_out=0x3E7.
